// File: rtl/text_console_pkg.sv
// ---------------------------------------------------------------------------
// text_console_pkg
// Shared definitions for the text console sequencer: screen geometry
// defaults, control-code values, the sequencer state encoding, the blank
// fill character and the address helper that places a screen position on
// either the character or the attribute plane.
// Configuration macro: TEXT_CONSOLE_SCROLL_EN (adds the scroll read/write
// states to the state encoding).
// ---------------------------------------------------------------------------
package text_console_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 30;
  localparam logic [7:0] DEF_ATTR_DEFAULT = 8'h0F;

  localparam int ADR_W     = 13;
  localparam int POS_W     = 12;
  localparam int PLANE_BIT = 12;

  localparam logic [7:0] CC_BS     = 8'h08;
  localparam logic [7:0] CC_LF     = 8'h0A;
  localparam logic [7:0] CC_FF     = 8'h0C;
  localparam logic [7:0] CC_CR     = 8'h0D;
  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CHR  = 3'd1,
    S_WR_ATR  = 3'd2,
    S_NEWLINE = 3'd3,
`ifdef TEXT_CONSOLE_SCROLL_EN
    S_SCR_RD  = 3'd4,
    S_SCR_WR  = 3'd5,
`endif
    S_FILL    = 3'd6,
    S_HOME    = 3'd7
  } state_t;

  // Builds a RAM address from a plane select and a linear screen position.
  function automatic logic [ADR_W-1:0] make_adr(input logic plane,
                                                input logic [POS_W-1:0] pos);
    logic [ADR_W-1:0] a;
    a            = {1'b0, pos};
    a[PLANE_BIT] = plane;
    return a;
  endfunction

endpackage

// File: rtl/text_console_ctrl_bus.sv
// ---------------------------------------------------------------------------
// console_bus_master
// Single-access Wishbone master. A one-cycle start pulse loads address,
// data and direction and raises cyc/stb on the next edge; the access ends
// on the edge where m_ack_i is seen, so cyc/stb drop the cycle after ack.
// done is combinational (cyc & ack) so the sequencer can queue the next
// access on the same edge and keep accesses back to back.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, we, adr, dat request from the sequencer
//   done, rdata         completion strobe and read data (valid with done)
//   m_*                 Wishbone master signals
// ---------------------------------------------------------------------------
module console_bus_master
  import text_console_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             we,
  input  logic [ADR_W-1:0] adr,
  input  logic [7:0]       dat,
  output logic             done,
  output logic [7:0]       rdata,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [7:0]       m_dat_o,
  input  logic [7:0]       m_dat_i,
  output logic             m_we_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  input  logic             m_ack_i
);

  // Bus cycle register: load on start, release on ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else if (start && !m_cyc_o) begin
      m_cyc_o <= 1'b1;
      m_stb_o <= 1'b1;
      m_we_o  <= we;
      m_adr_o <= adr;
      m_dat_o <= dat;
    end else if (m_cyc_o && m_ack_i) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
    end
  end

  assign done  = m_cyc_o & m_ack_i;
  assign rdata = m_dat_i;

endmodule

// File: rtl/text_console_ctrl.sv
// ---------------------------------------------------------------------------
// text_console_ctrl
// Terminal-style sequencer owning the Wishbone port of the 80x30 text
// character/attribute RAM. Accepts a byte stream, keeps a cursor, and
// issues single bus accesses to place glyphs, clear the screen and scroll.
// Configuration macro: TEXT_CONSOLE_SCROLL_EN
//   defined   - newline on the last row scrolls the screen up one row
//   undefined - newline on the last row wraps to row 0 and blanks it
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   ch_valid/ch_data/ch_ready byte stream handshake
//   attr_i                  attribute for the next printable character
//   m_*                     Wishbone master to the text RAM
//   cur_col, cur_row        cursor position
//   busy                    high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int         COLS     = COLS_DEFAULT,
  parameter int         ROWS     = ROWS_DEFAULT,
  parameter logic [7:0] DEF_ATTR = DEF_ATTR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_valid,
  input  logic [7:0]       ch_data,
  output logic             ch_ready,
  input  logic [7:0]       attr_i,
  output logic [ADR_W-1:0] m_adr_o,
  output logic [7:0]       m_dat_o,
  input  logic [7:0]       m_dat_i,
  output logic             m_we_o,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  input  logic             m_ack_i,
  output logic [6:0]       cur_col,
  output logic [4:0]       cur_row,
  output logic             busy
);

  localparam logic [6:0]       LAST_COL       = 7'(COLS - 1);
  localparam logic [4:0]       LAST_ROW       = 5'(ROWS - 1);
  localparam logic [POS_W-1:0] COLS_POS       = POS_W'(COLS);
  localparam logic [POS_W-1:0] LAST_COL_POS   = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0] LAST_POS       = POS_W'(COLS * ROWS - 1);
  localparam logic [POS_W-1:0] LAST_ROW_START = POS_W'(COLS * (ROWS - 1));

  state_t           state;
  logic [6:0]       col;
  logic [4:0]       row;
  logic [7:0]       attr_q;
  logic [POS_W-1:0] idx;
  logic [POS_W-1:0] fill_start;
  logic [POS_W-1:0] fill_end;
  logic             plane;
  logic             fill_home;

  logic             start;
  logic             req_we;
  logic [ADR_W-1:0] req_adr;
  logic [7:0]       req_dat;
  logic             done;
  logic [7:0]       rdata;
  logic [POS_W-1:0] pos;

  assign pos      = POS_W'(int'(row) * COLS + int'(col));
  assign ch_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign cur_col  = col;
  assign cur_row  = row;

`ifndef TEXT_CONSOLE_SCROLL_EN
  logic rdata_unused;
  assign rdata_unused = ^rdata;
`endif

  console_bus_master u_bus (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .we      (req_we),
    .adr     (req_adr),
    .dat     (req_dat),
    .done    (done),
    .rdata   (rdata),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_we_o  (m_we_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_ack_i (m_ack_i)
  );

  // Sequencer: decodes accepted bytes and walks the glyph, fill and scroll
  // sequences. Every bus request is a one-cycle start pulse issued on the
  // same edge the previous access completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      attr_q     <= DEF_ATTR;
      idx        <= '0;
      fill_start <= '0;
      fill_end   <= '0;
      plane      <= 1'b0;
      fill_home  <= 1'b0;
      start      <= 1'b0;
      req_we     <= 1'b0;
      req_adr    <= '0;
      req_dat    <= '0;
    end else begin
      start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ch_valid) begin
            attr_q <= attr_i;
            if (ch_data == CC_CR) begin
              col <= '0;
            end else if (ch_data == CC_LF) begin
              col   <= '0;
              state <= S_NEWLINE;
            end else if (ch_data == CC_BS) begin
              if (col != '0) col <= col - 7'd1;
            end else if (ch_data == CC_FF) begin
              idx        <= '0;
              fill_start <= '0;
              fill_end   <= LAST_POS;
              plane      <= 1'b0;
              fill_home  <= 1'b1;
              start      <= 1'b1;
              req_we     <= 1'b1;
              req_adr    <= make_adr(1'b0, '0);
              req_dat    <= FILL_CHAR;
              state      <= S_FILL;
            end else if (ch_data >= FILL_CHAR) begin
              start   <= 1'b1;
              req_we  <= 1'b1;
              req_adr <= make_adr(1'b0, pos);
              req_dat <= ch_data;
              state   <= S_WR_CHR;
            end
          end
        end

        S_WR_CHR: begin
          if (done) begin
            start   <= 1'b1;
            req_we  <= 1'b1;
            req_adr <= make_adr(1'b1, pos);
            req_dat <= attr_q;
            state   <= S_WR_ATR;
          end
        end

        S_WR_ATR: begin
          if (done) begin
            if (col == LAST_COL) begin
              col   <= '0;
              state <= S_NEWLINE;
            end else begin
              col   <= col + 7'd1;
              state <= S_IDLE;
            end
          end
        end

        S_NEWLINE: begin
          if (row != LAST_ROW) begin
            row   <= row + 5'd1;
            state <= S_IDLE;
          end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
            // Start the upward copy at row 1 of the character plane.
            idx     <= COLS_POS;
            plane   <= 1'b0;
            start   <= 1'b1;
            req_we  <= 1'b0;
            req_adr <= make_adr(1'b0, COLS_POS);
            state   <= S_SCR_RD;
`else
            // Wrap-around console: back to row 0 and blank it.
            row        <= '0;
            idx        <= '0;
            fill_start <= '0;
            fill_end   <= LAST_COL_POS;
            plane      <= 1'b0;
            fill_home  <= 1'b0;
            start      <= 1'b1;
            req_we     <= 1'b1;
            req_adr    <= make_adr(1'b0, '0);
            req_dat    <= FILL_CHAR;
            state      <= S_FILL;
`endif
          end
        end

`ifdef TEXT_CONSOLE_SCROLL_EN
        S_SCR_RD: begin
          if (done) begin
            start   <= 1'b1;
            req_we  <= 1'b1;
            req_adr <= make_adr(plane, idx - COLS_POS);
            req_dat <= rdata;
            state   <= S_SCR_WR;
          end
        end

        // Ascending copy order is what keeps unread source cells intact.
        S_SCR_WR: begin
          if (done) begin
            if (idx == LAST_POS) begin
              if (!plane) begin
                plane   <= 1'b1;
                idx     <= COLS_POS;
                start   <= 1'b1;
                req_we  <= 1'b0;
                req_adr <= make_adr(1'b1, COLS_POS);
                state   <= S_SCR_RD;
              end else begin
                plane      <= 1'b0;
                idx        <= LAST_ROW_START;
                fill_start <= LAST_ROW_START;
                fill_end   <= LAST_POS;
                fill_home  <= 1'b0;
                start      <= 1'b1;
                req_we     <= 1'b1;
                req_adr    <= make_adr(1'b0, LAST_ROW_START);
                req_dat    <= FILL_CHAR;
                state      <= S_FILL;
              end
            end else begin
              idx     <= idx + 12'd1;
              start   <= 1'b1;
              req_we  <= 1'b0;
              req_adr <= make_adr(plane, idx + 12'd1);
              state   <= S_SCR_RD;
            end
          end
        end
`endif

        // Fill the range on the character plane, then the attribute plane.
        S_FILL: begin
          if (done) begin
            if (idx == fill_end) begin
              if (!plane) begin
                plane   <= 1'b1;
                idx     <= fill_start;
                start   <= 1'b1;
                req_we  <= 1'b1;
                req_adr <= make_adr(1'b1, fill_start);
                req_dat <= attr_q;
              end else begin
                plane <= 1'b0;
                state <= fill_home ? S_HOME : S_IDLE;
              end
            end else begin
              idx     <= idx + 12'd1;
              start   <= 1'b1;
              req_we  <= 1'b1;
              req_adr <= make_adr(plane, idx + 12'd1);
              req_dat <= plane ? attr_q : FILL_CHAR;
            end
          end
        end

        S_HOME: begin
          col   <= '0;
          row   <= '0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_console_ctrl
// Bench for text_console_ctrl: a Wishbone RAM responder with adjustable ack
// stall, and a screen/cursor reference model built from the console rules
// (array shifts and fills). Follows TEXT_CONSOLE_SCROLL_EN like the design.
// ---------------------------------------------------------------------------
module tb_text_console_ctrl;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int SCREEN = COLS * ROWS;
  localparam int LIMIT  = 40000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [7:0]  attr_i;
  logic [12:0] m_adr_o;
  logic [7:0]  m_dat_o;
  logic [7:0]  m_dat_i;
  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_ack_i;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  logic [7:0]  ram_chr [SCREEN];
  logic [7:0]  ram_atr [SCREEN];
  logic [7:0]  exp_chr [SCREEN];
  logic [7:0]  exp_atr [SCREEN];
  logic [12:0] wlog_adr [$];
  logic [7:0]  wlog_dat [$];

  int m_col = 0;
  int m_row = 0;
  int stall_cycles = 0;
  int wait_cnt = 0;
  int preload_kind = 0;
  int read_count = 0;
  int oob_count = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .attr_i   (attr_i),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (m_dat_i),
    .m_we_o   (m_we_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack_i),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  // RAM responder: acks after stall_cycles wait states, logs every write.
  assign m_ack_i = m_cyc_o && m_stb_o && (wait_cnt >= stall_cycles);
  assign m_dat_i = (m_adr_o[11:0] < 12'd2400) ?
                   (m_adr_o[12] ? ram_atr[m_adr_o[11:0]] : ram_chr[m_adr_o[11:0]]) : 8'h00;

  always @(posedge clk) begin
    if (preload_kind == 1) begin
      for (int i = 0; i < SCREEN; i++) begin
        ram_chr[i] = 8'($urandom);
        ram_atr[i] = 8'($urandom);
      end
    end else if (preload_kind == 2) begin
      for (int i = 0; i < SCREEN; i++) begin
        ram_chr[i] = 8'(i);
        ram_atr[i] = 8'(i);
      end
    end
    if (m_cyc_o && m_stb_o && !m_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (m_ack_i) begin
      if (m_adr_o[11:0] >= 12'd2400) begin
        oob_count++;
      end else if (m_we_o) begin
        if (m_adr_o[12]) ram_atr[m_adr_o[11:0]] = m_dat_o;
        else ram_chr[m_adr_o[11:0]] = m_dat_o;
        wlog_adr.push_back(m_adr_o);
        wlog_dat.push_back(m_dat_o);
      end else begin
        read_count++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: cursor and screen arrays updated from the console rules.
  task automatic modelNewline(input logic [7:0] a);
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      for (int p = COLS; p < SCREEN; p++) begin
        exp_chr[p - COLS] = exp_chr[p];
        exp_atr[p - COLS] = exp_atr[p];
      end
      for (int p = SCREEN - COLS; p < SCREEN; p++) begin
        exp_chr[p] = 8'h20;
        exp_atr[p] = a;
      end
`else
      m_row = 0;
      for (int p = 0; p < COLS; p++) begin
        exp_chr[p] = 8'h20;
        exp_atr[p] = a;
      end
`endif
    end
  endtask

  task automatic modelByte(input logic [7:0] b, input logic [7:0] a);
    int p;
    if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      modelNewline(a);
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      for (int i = 0; i < SCREEN; i++) begin
        exp_chr[i] = 8'h20;
        exp_atr[i] = a;
      end
      m_col = 0;
      m_row = 0;
    end else if (b >= 8'h20) begin
      p = m_row * COLS + m_col;
      exp_chr[p] = b;
      exp_atr[p] = a;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        modelNewline(a);
      end
    end
  endtask

  task automatic copyRamToModel();
    for (int i = 0; i < SCREEN; i++) begin
      exp_chr[i] = ram_chr[i];
      exp_atr[i] = ram_atr[i];
    end
  endtask

  task automatic preload(input int kind);
    preload_kind = kind;
    @(posedge clk);
    #1 preload_kind = 0;
    @(negedge clk);
  endtask

  task automatic compareScreen(input string tag);
    int mc = 0;
    int ma = 0;
    for (int i = 0; i < SCREEN; i++) begin
      if (ram_chr[i] !== exp_chr[i]) mc++;
      if (ram_atr[i] !== exp_atr[i]) ma++;
    end
    checkOutput({tag, "_chr_diffs"}, 32'(mc), 32'd0);
    checkOutput({tag, "_atr_diffs"}, 32'(ma), 32'd0);
    checkOutput({tag, "_col"}, 32'(cur_col), 32'(m_col));
    checkOutput({tag, "_row"}, 32'(cur_row), 32'(m_row));
  endtask

  // Sends one byte (caller sits at a negedge) and waits for ch_ready again.
  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] a, output int lat);
    int n = 0;
    while (ch_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (ch_ready !== 1'b1) checkOutput("ready_timeout", 32'(ch_ready), 32'd1);
    ch_valid = 1'b1;
    ch_data  = b;
    attr_i   = a;
    @(posedge clk);
    modelByte(b, a);
    @(negedge clk);
    ch_valid = 1'b0;
    lat = 0;
    while (ch_ready !== 1'b1 && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (ch_ready !== 1'b1) checkOutput("done_timeout", 32'(ch_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int base;
    int rd0;
    int cnt;
    int cnt2;
    logic [7:0] b;
    logic [7:0] a;

    rst_n    = 1'b0;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    attr_i   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload(1);
    copyRamToModel();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("rst_ch_ready", 32'(ch_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_col", 32'(cur_col), 32'd0);
    checkOutput("rst_row", 32'(cur_row), 32'd0);
    checkOutput("rst_cyc", 32'(m_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(m_stb_o), 32'd0);
    checkOutput("rst_we", 32'(m_we_o), 32'd0);
    checkOutput("rst_adr", 32'(m_adr_o), 32'd0);
    checkOutput("rst_dat", 32'(m_dat_o), 32'd0);

    // Single printable
    base = wlog_adr.size();
    applyStimulus(8'h41, 8'h1E, lat);
    checkOutput("A_nwrites", 32'(wlog_adr.size() - base), 32'd2);
    if (wlog_adr.size() >= base + 2) begin
      checkOutput("A_adr0", 32'(wlog_adr[base]), 32'h0000);
      checkOutput("A_dat0", 32'(wlog_dat[base]), 32'h41);
      checkOutput("A_adr1", 32'(wlog_adr[base + 1]), 32'h1000);
      checkOutput("A_dat1", 32'(wlog_dat[base + 1]), 32'h1E);
    end
    checkOutput("A_latency", 32'(lat), 32'd4);
    checkOutput("A_col", 32'(cur_col), 32'd1);
    checkOutput("A_ready", 32'(ch_ready), 32'd1);

    // Full row of printables wraps to the next row
    applyStimulus(8'h0D, 8'h0F, lat);
    base = wlog_adr.size();
    for (int i = 0; i < COLS; i++) applyStimulus(8'(8'h61 + i % 26), 8'($urandom), lat);
    checkOutput("row_nwrites", 32'(wlog_adr.size() - base), 32'(2 * COLS));
    checkOutput("row_last_adr", 32'(wlog_adr[wlog_adr.size() - 1]), 32'h104F);
    cnt = 0;
    for (int i = base; i < wlog_adr.size(); i++) if (wlog_adr[i][11:0] == 12'd80) cnt++;
    checkOutput("row_no_pos80", 32'(cnt), 32'd0);
    checkOutput("row_col", 32'(cur_col), 32'd0);
    checkOutput("row_row", 32'(cur_row), 32'd1);
    compareScreen("row");

    // Random byte mix (no form feed)
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 255));
        6: b = 8'h0D;
        7: b = 8'h08;
        8: b = 8'h0A;
        default: begin
          b = 8'($urandom_range(0, 31));
          if (b == 8'h0C) b = 8'h00;
        end
      endcase
      applyStimulus(b, 8'($urandom), lat);
    end
    compareScreen("rand");

    // Form feed clears both planes
    base = wlog_adr.size();
    applyStimulus(8'h0C, 8'h07, lat);
    cnt = 0;
    cnt2 = 0;
    for (int i = base; i < wlog_adr.size(); i++) begin
      if (!wlog_adr[i][12] && wlog_dat[i] == 8'h20) cnt++;
      if (wlog_adr[i][12] && wlog_dat[i] == 8'h07) cnt2++;
    end
    checkOutput("ff_chr_writes", 32'(cnt), 32'(SCREEN));
    checkOutput("ff_atr_writes", 32'(cnt2), 32'(SCREEN));
    compareScreen("ff");

    // Newline on the last row
    for (int i = 0; i < ROWS - 1; i++) applyStimulus(8'h0A, 8'h0F, lat);
    checkOutput("lf_row29", 32'(cur_row), 32'd29);
    preload(2);
    copyRamToModel();
    rd0 = read_count;
    a = 8'($urandom);
    applyStimulus(8'h0A, a, lat);
`ifdef TEXT_CONSOLE_SCROLL_EN
    checkOutput("scroll_pos0", 32'(ram_chr[0]), 32'h50);
    checkOutput("scroll_pos2319", 32'(ram_chr[2319]), 32'h5F);
    checkOutput("scroll_atr0", 32'(ram_atr[0]), 32'h50);
    cnt = 0;
    for (int p = SCREEN - COLS; p < SCREEN; p++) if (ram_chr[p] == 8'h20 && ram_atr[p] == a) cnt++;
    checkOutput("scroll_blank_row", 32'(cnt), 32'(COLS));
    checkOutput("scroll_row", 32'(cur_row), 32'd29);
`else
    cnt = 0;
    for (int p = 0; p < COLS; p++) if (ram_chr[p] == 8'h20 && ram_atr[p] == a) cnt++;
    checkOutput("wrap_blank_row", 32'(cnt), 32'(COLS));
    checkOutput("wrap_row", 32'(cur_row), 32'd0);
    checkOutput("wrap_reads", 32'(read_count - rd0), 32'd0);
    checkOutput("wrap_pos80", 32'(ram_chr[80]), 32'h50);
`endif
    compareScreen("lf_last");

    // Reset in the middle of a long operation with stalled acks
    stall_cycles = 5;
    ch_valid = 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
    ch_data = 8'h0A;
`else
    ch_data = 8'h0C;
`endif
    attr_i = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_cyc", 32'(m_cyc_o), 32'd0);
    checkOutput("abort_stb", 32'(m_stb_o), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(ch_ready), 32'd1);
    checkOutput("abort_col", 32'(cur_col), 32'd0);
    checkOutput("abort_row", 32'(cur_row), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_cycles = 0;
    @(negedge clk);
    copyRamToModel();
    m_col = 0;
    m_row = 0;

    // Backspace at column 0 and after one character
    applyStimulus(8'h08, 8'h0F, lat);
    checkOutput("bs_col0", 32'(cur_col), 32'd0);
    applyStimulus(8'h5A, 8'h2A, lat);
    checkOutput("z_col", 32'(cur_col), 32'd1);
    applyStimulus(8'h08, 8'h0F, lat);
    checkOutput("bs_col1", 32'(cur_col), 32'd0);
    compareScreen("post_reset");

    checkOutput("adr_in_range", 32'(oob_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
